// File: rtl/comm_vh_gen.sv
// comm_vh_gen - parametrised video-timing generator for N-pixel-per-clock streams.
//
// Walks a horizontal beat counter (hcnt) and a vertical line counter (vcnt)
// over the full frame raster (blanking + porches + active window). From the
// counter position it produces the active-window syncs, the pixel
// coordinates and the line/frame pulses. It runs FRM frames per start
// request, or runs forever when FRM == 0.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous reset, active-low
//   enable       in   master enable; low returns to IDLE and masks VSYNC/HSYNC at once
//   start        in   run request, sampled in IDLE/DONE
//   pause        in   freeze counters and outputs while high
//   VSYNC        out  vertical active window
//   HSYNC        out  horizontal active window (only inside VSYNC)
//   frame_start  out  1-cycle pulse on the first HSYNC beat of a frame
//   line_start   out  1-cycle pulse on the first HSYNC beat of each line
//   x_pos        out  pixel index of lane 0 on the current beat (0 outside HSYNC)
//   y_pos        out  active-line index (0 outside VSYNC)
//   frame_idx    out  frames completed in this run
//   busy         out  running
//   done         out  run finished (FRM frames produced)
//
// The sync/coordinate/pulse outputs are registered. Each one shows the
// counter value from the previous clock. On the clock that moves the FSM to
// DONE, the final active beat is still presented. Every later DONE cycle
// drives those outputs to 0.

module comm_vh_gen #(
    parameter int CW      = 13,
    parameter int FW      = 4,
    parameter int FRM     = 3,
    parameter int PPC     = 1,
    parameter int VBLK    = 100,
    parameter int V_BP    = 5,
    parameter int V_FP    = 5,
    parameter int V_WIDTH = 2048,
    parameter int HBLK    = 20,
    parameter int H_BP    = 0,
    parameter int H_FP    = 0,
    parameter int H_WIDTH = 2448
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    input  logic          pause,
    output logic          VSYNC,
    output logic          HSYNC,
    output logic          frame_start,
    output logic          line_start,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic [FW-1:0] frame_idx,
    output logic          busy,
    output logic          done
);

    localparam int H_TOT = (HBLK + H_BP + H_WIDTH + H_FP) / PPC;
    localparam int V_TOT = VBLK + V_BP + V_WIDTH + V_FP;
    localparam int T_MAX = (H_TOT > V_TOT) ? H_TOT : V_TOT;

    // Elaboration-time sanity checks on the geometry.
    if (PPC != 1 && PPC != 2 && PPC != 4) begin : g_bad_ppc
        $error("comm_vh_gen: PPC must be 1, 2 or 4");
    end
    if ((HBLK % PPC) != 0 || (H_BP % PPC) != 0 || (H_WIDTH % PPC) != 0 || (H_FP % PPC) != 0) begin : g_bad_hdiv
        $error("comm_vh_gen: horizontal timing not divisible by PPC");
    end
    if (longint'(T_MAX - 1) >= (longint'(1) << CW) || longint'(V_WIDTH - 1) >= (longint'(1) << CW)) begin : g_bad_cw
        $error("comm_vh_gen: CW too narrow for frame geometry");
    end

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_FIRST = CW'((HBLK + H_BP) / PPC);
    localparam logic [CW-1:0] H_END   = CW'((HBLK + H_BP + H_WIDTH) / PPC - 1);
    localparam logic [CW-1:0] V_FIRST = CW'(VBLK + V_BP);
    localparam logic [CW-1:0] V_END   = CW'(VBLK + V_BP + V_WIDTH - 1);
    localparam logic [CW-1:0] PPC_C   = CW'(PPC);
    localparam logic [FW-1:0] F_LAST  = FW'((FRM == 0) ? 0 : FRM - 1);
    localparam logic [FW-1:0] F_TOTAL = FW'(FRM);
    localparam bit            FREE    = (FRM == 0);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t        state;
    logic [CW-1:0] hcnt, vcnt;
    logic [FW-1:0] fcnt;
    logic          vs_q, hs_q;

    logic          v_act, h_act, h_wrap, v_wrap;
    logic [CW-1:0] h_off, x_nxt;

    assign v_act  = (vcnt >= V_FIRST) && (vcnt <= V_END);
    assign h_act  = v_act && (hcnt >= H_FIRST) && (hcnt <= H_END);
    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);
    assign h_off  = hcnt - H_FIRST;
    assign x_nxt  = h_off * PPC_C;

    // The enable mask is the only combinational path to an output. It
    // stops the syncs in the same cycle that enable falls.
    assign VSYNC = vs_q & enable;
    assign HSYNC = hs_q & enable;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            fcnt        <= '0;
            frame_idx   <= '0;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            fcnt        <= '0;
            frame_idx   <= '0;
            vs_q        <= 1'b0;
            hs_q        <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    vs_q        <= 1'b0;
                    hs_q        <= 1'b0;
                    frame_start <= 1'b0;
                    line_start  <= 1'b0;
                    x_pos       <= '0;
                    y_pos       <= '0;
                    if (start) begin
                        // Counters are already 0 in both states. Only the frame
                        // count carries over from DONE, so clear it here.
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fcnt      <= '0;
                        frame_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        // Hold everything, but never repeat a pulse.
                        frame_start <= 1'b0;
                        line_start  <= 1'b0;
                    end else begin
                        vs_q        <= v_act;
                        hs_q        <= h_act;
                        line_start  <= h_act && (hcnt == H_FIRST);
                        frame_start <= h_act && (hcnt == H_FIRST) && (vcnt == V_FIRST);
                        x_pos       <= h_act ? x_nxt : '0;
                        y_pos       <= v_act ? (vcnt - V_FIRST) : '0;
                        if (!h_wrap) begin
                            hcnt <= hcnt + 1'b1;
                        end else begin
                            hcnt <= '0;
                            if (!v_wrap) begin
                                vcnt <= vcnt + 1'b1;
                            end else begin
                                vcnt <= '0;
                                if (!FREE && (fcnt == F_LAST)) begin
                                    state     <= ST_DONE;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    fcnt      <= '0;
                                    frame_idx <= F_TOTAL;
                                end else begin
                                    fcnt      <= fcnt + 1'b1;
                                    frame_idx <= fcnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_vh_gen.sv
// Bench for comm_vh_gen using the small 6x3 raster.
// The bench instantiates three configurations:
//   dut     : PPC=1, FRM=2
//   dut_fr  : PPC=1, FRM=0 (free-run)
//   dut_p2  : PPC=2, FRM=2
// Expected HSYNC beats of dut are queued when a run starts. A negedge monitor
// pops one entry for every new beat. Directed checks pin down exact timing.

module tb_comm_vh_gen;

    localparam int CW = 13;
    localparam int FW = 4;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
    } beat_t;

    logic clk, rst, enable, pause, start, start_fr, start_p2;

    logic vs, hs, fs, ls, bz, dn;
    logic [CW-1:0] xp, yp;
    logic [FW-1:0] fi;

    logic vs_fr, hs_fr, fs_fr, ls_fr, bz_fr, dn_fr;
    logic [CW-1:0] xp_fr, yp_fr;
    logic [FW-1:0] fi_fr;

    logic vs_p2, hs_p2, fs_p2, ls_p2, bz_p2, dn_p2;
    logic [CW-1:0] xp_p2, yp_p2;
    logic [FW-1:0] fi_p2;

    comm_vh_gen #(.CW(CW), .FW(FW), .FRM(2), .PPC(1), .VBLK(1), .V_BP(0), .V_FP(0), .V_WIDTH(2),
                  .HBLK(2), .H_BP(0), .H_FP(0), .H_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .pause(pause),
        .VSYNC(vs), .HSYNC(hs), .frame_start(fs), .line_start(ls),
        .x_pos(xp), .y_pos(yp), .frame_idx(fi), .busy(bz), .done(dn));

    comm_vh_gen #(.CW(CW), .FW(FW), .FRM(0), .PPC(1), .VBLK(1), .V_BP(0), .V_FP(0), .V_WIDTH(2),
                  .HBLK(2), .H_BP(0), .H_FP(0), .H_WIDTH(4)) dut_fr (
        .clk(clk), .rst(rst), .enable(enable), .start(start_fr), .pause(pause),
        .VSYNC(vs_fr), .HSYNC(hs_fr), .frame_start(fs_fr), .line_start(ls_fr),
        .x_pos(xp_fr), .y_pos(yp_fr), .frame_idx(fi_fr), .busy(bz_fr), .done(dn_fr));

    comm_vh_gen #(.CW(CW), .FW(FW), .FRM(2), .PPC(2), .VBLK(1), .V_BP(0), .V_FP(0), .V_WIDTH(2),
                  .HBLK(2), .H_BP(0), .H_FP(0), .H_WIDTH(4)) dut_p2 (
        .clk(clk), .rst(rst), .enable(enable), .start(start_p2), .pause(pause),
        .VSYNC(vs_p2), .HSYNC(hs_p2), .frame_start(fs_p2), .line_start(ls_p2),
        .x_pos(xp_p2), .y_pos(yp_p2), .frame_idx(fi_p2), .busy(bz_p2), .done(dn_p2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    int    ls_cnt = 0;
    int    fs_cnt = 0;
    int    done_hits = 0;
    beat_t sb[$];
    logic [CW-1:0] last_x = '0;
    logic  pz = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    // Wait n rising edges, then settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the 16 beats of one FRM=2 run of the primary DUT.
    task automatic push_run();
        for (int f = 0; f < 2; f++)
            for (int y = 0; y < 2; y++)
                for (int x = 0; x < 4; x++) begin
                    beat_t b;
                    b.x  = CW'(x);
                    b.y  = CW'(y);
                    b.ls = (x == 0);
                    b.fs = (x == 0) && (y == 0);
                    sb.push_back(b);
                end
    endtask

    // Record the pause level that the DUT saw on this edge.
    always @(posedge clk) pz <= pause;

    // Scoreboard monitor for the primary DUT.
    always @(negedge clk) begin
        if (rst && hs) begin
            if (pz) begin
                chk("pause_hold", {xp, ls, fs}, {last_x, 2'b00});
            end else if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL beat_unexpected: got beat x=%0d y=%0d, want none", xp, yp);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat", {xp, yp, ls, fs}, {e.x, e.y, e.ls, e.fs});
                last_x = xp;
                ls_cnt += int'(ls);
                fs_cnt += int'(fs);
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; pause = 1'b0;
        start = 1'b0; start_fr = 1'b0; start_p2 = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("reset_outs", {vs, hs, fs, ls, xp, yp, fi, bz, dn}, '0);
        edges(2);
        rst = 1'b1;
        edges(1);

        // Basic run: timing of the first line, a stray start while running, and done.
        push_run(); ls_cnt = 0; fs_cnt = 0;
        start = 1'b1; edges(1); start = 1'b0;             // E0
        chk("t1_busy", {bz, dn}, 2'b10);
        edges(3); start = 1'b1; edges(1); start = 1'b0;   // E4: ignored
        edges(4);                                          // E8
        chk("t1_pre", {vs, hs}, 2'b10);
        edges(1);                                          // E9
        chk("t1_first", {hs, ls, fs, xp, yp}, {3'b111, 13'd0, 13'd0});
        edges(6);                                          // E15
        chk("t1_line2", {hs, ls, fs, xp, yp}, {3'b110, 13'd0, 13'd1});
        edges(20);                                         // E35
        chk("t2_pre_done", {bz, dn}, 2'b10);
        edges(1);                                          // E36
        chk("t2_done", {bz, dn, fi}, {2'b01, 4'd2});
        edges(1);                                          // E37
        chk("t2_idle_outs", {vs, hs, dn, fi, xp, yp}, {3'b001, 4'd2, 13'd0, 13'd0});
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        chk("t2_lines", 64'(ls_cnt), 64'd4);
        chk("t2_frames", 64'(fs_cnt), 64'd2);

        // Restart from DONE with a 3-cycle pause at x_pos=1.
        push_run(); ls_cnt = 0; fs_cnt = 0;
        start = 1'b1; edges(1); start = 1'b0;             // E0
        chk("t5_restart", {bz, dn, fi}, {2'b10, 4'd0});
        edges(10);                                         // E10
        chk("t5_x1", {hs, xp}, {1'b1, 13'd1});
        pause = 1'b1; edges(3);                            // E13
        chk("t5_held", {hs, ls, xp}, {2'b10, 13'd1});
        pause = 1'b0; edges(1);                            // E14
        chk("t5_resume", {hs, xp}, {1'b1, 13'd2});
        edges(24);                                         // E38
        chk("t5_pre_done", {dn}, 1'b0);
        edges(1);                                          // E39
        chk("t5_done", {dn, fi}, {1'b1, 4'd2});
        edges(1);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk("t5_lines", 64'(ls_cnt), 64'd4);
        chk("t5_frames", 64'(fs_cnt), 64'd2);

        // PPC=2: 3 beats per line, 9 clocks per frame.
        start_p2 = 1'b1; edges(1); start_p2 = 1'b0;       // E0
        edges(4);                                          // E4
        chk("t4_pre", {vs_p2, hs_p2}, 2'b10);
        edges(1);                                          // E5
        chk("t4_beat0", {hs_p2, ls_p2, fs_p2, xp_p2, yp_p2}, {3'b111, 13'd0, 13'd0});
        edges(1);                                          // E6
        chk("t4_beat1", {hs_p2, ls_p2, fs_p2, xp_p2}, {3'b100, 13'd2});
        edges(1);                                          // E7
        chk("t4_gap", {vs_p2, hs_p2}, 2'b10);
        edges(1);                                          // E8
        chk("t4_line2", {hs_p2, ls_p2, fs_p2, xp_p2, yp_p2}, {3'b110, 13'd0, 13'd1});
        edges(9);                                          // E17
        chk("t4_pre_done", {dn_p2}, 1'b0);
        edges(1);                                          // E18
        chk("t4_done", {dn_p2, fi_p2}, {1'b1, 4'd2});

        // Free-run: 20 frames, frame_idx wraps at 16, done never set.
        start_fr = 1'b1; edges(1); start_fr = 1'b0;       // E0
        done_hits = 0;
        for (int i = 1; i <= 360; i++) begin
            edges(1);
            if (dn_fr) done_hits++;
            if (i == 17)  chk("t3_fi17", 64'(fi_fr), 64'd0);
            if (i == 18)  chk("t3_fi18", 64'(fi_fr), 64'd1);
            if (i == 287) chk("t3_fi287", 64'(fi_fr), 64'd15);
            if (i == 288) chk("t3_wrap", 64'(fi_fr), 64'd0);
        end
        chk("t3_fi_end", {bz_fr, fi_fr}, {1'b1, 4'd4});
        chk("t3_no_done", 64'(done_hits), 64'd0);

        // Asynchronous reset in the middle of a run.
        sb.delete(); push_run();
        start = 1'b1; edges(1); start = 1'b0;
        edges(10);
        chk("t6_mid", {hs, xp}, {1'b1, 13'd1});
        #2 rst = 1'b0;
        #1;
        chk("t6_async_rst", {vs, hs, fs, ls, xp, yp, fi, bz, dn}, '0);
        sb.delete();
        edges(1); rst = 1'b1; edges(2);
        chk("t6_after_rst", {bz, dn, hs}, 3'b000);

        // enable low in the middle of a run.
        push_run();
        start = 1'b1; edges(1); start = 1'b0;
        edges(10);
        chk("t6_en_mid", {hs, vs, xp}, {2'b11, 13'd1});
        enable = 1'b0; #1;
        chk("t6_en_gate", {vs, hs, bz}, 3'b001);
        edges(1);
        chk("t6_en_idle", {bz, dn, xp, yp, fi}, '0);
        sb.delete();
        start = 1'b1; edges(1);
        chk("t6_start_noen", {bz}, 1'b0);
        start = 1'b0; enable = 1'b1; edges(2);
        chk("t6_no_latch", {bz, hs}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
